// File: rtl/gpi_debounce.sv
// Per-channel synchroniser and debouncer for the general-purpose input bus, with
// registered rise/fall/change pulses. Define GPI_DEBOUNCE_IRQ_EN to get a sticky irq_o.
module gpi_debounce #(
  parameter int unsigned         GpiWidth       = 8,
  parameter int unsigned         DebounceCycles = 500000,
  parameter logic [GpiWidth-1:0] GpiResetVal    = '0
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic [GpiWidth-1:0] gp_raw_i,
  output logic [GpiWidth-1:0] gp_o,
  output logic [GpiWidth-1:0] rise_o,
  output logic [GpiWidth-1:0] fall_o,
  output logic                change_o,
  output logic                irq_o,
  input  logic                irq_clr_i
);

  localparam int unsigned          CtrWidth  = $clog2(DebounceCycles + 1);
  localparam logic [CtrWidth-1:0]  LastCount = CtrWidth'(DebounceCycles - 1);

  logic [GpiWidth-1:0] sync1_q, sync2_q;
  logic [GpiWidth-1:0] gp_q, gp_d;
  logic [GpiWidth-1:0] rise_q, rise_d;
  logic [GpiWidth-1:0] fall_q, fall_d;
  logic                change_q;
  logic [CtrWidth-1:0] ctr_q [GpiWidth];
  logic [CtrWidth-1:0] ctr_d [GpiWidth];

  // Two-flop chain: gp_raw_i is asynchronous to clk_sys_i.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= GpiResetVal;
      sync2_q <= GpiResetVal;
    end else begin
      sync1_q <= gp_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // A channel is pending while the synced level differs from the accepted one;
  // its counter then measures how long the new level has held.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    gp_d   = gp_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(GpiWidth); i++) begin
      ctr_d[i] = '0;
      if (sync2_q[i] != gp_q[i]) begin
        if (ctr_q[i] == LastCount) begin
          gp_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          ctr_d[i] = ctr_q[i] + CtrWidth'(1);
        end
      end
    end
  end

  // The counters are individual reset flops, not a RAM, so all of them clear.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gp_q     <= GpiResetVal;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      for (int i = 0; i < int'(GpiWidth); i++) ctr_q[i] <= '0;
    end else begin
      gp_q     <= gp_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= |(rise_d | fall_d);
      for (int i = 0; i < int'(GpiWidth); i++) ctr_q[i] <= ctr_d[i];
    end
  end

  assign gp_o     = gp_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;

`ifdef GPI_DEBOUNCE_IRQ_EN
  // Set has priority so an acceptance coinciding with a clear is never lost.
  logic irq_q;
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni)     irq_q <= 1'b0;
    else if (change_q)   irq_q <= 1'b1;
    else if (irq_clr_i)  irq_q <= 1'b0;
  end
  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule
